// File: rtl/pattern_seq_sched.sv
// pattern_seq_sched
//   Shares one serial pattern generator between two requesters. A requester
//   presents pattern/length/repeat with reqN held high until ackN. The block
//   grants round-robin, latches the job and shifts the pattern out one bit per
//   clock for the requested number of repetitions (0 = run until abort).
//
// Build option:
//   PATTERN_SEQ_SCHED_LSB_FIRST_EN  defined   -> pat[0] first, pat[len] last
//                                   undefined -> pat[len] first (MSB-first)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req0_i / req1_i       request, held high until ack
//   pat0_i / pat1_i       pattern bits
//   len0_i / len1_i       pattern length minus one
//   rpt0_i / rpt1_i       repetitions, 0 = continuous
//   abort_i               terminate the running job
//   ack0_o / ack1_o       one-cycle accept pulse
//   data_out_o, data_vld_o serial bit and its valid
//   busy_o                job in progress
//   owner_o               channel of current or last job
//   done_o                pulse with the last valid bit of a job
//   aborted_o             pulse after an abort takes effect
//
// States:
//   IDLE | waiting for a request; arbitrates and latches the job
//   RUN  | shifting the latched pattern out

module pattern_seq_sched #(
    parameter int PAT_W = 16,
    parameter int LEN_W = $clog2(PAT_W),
    parameter int RPT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [PAT_W-1:0] pat0_i,
    input  logic [PAT_W-1:0] pat1_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [LEN_W-1:0] len1_i,
    input  logic [RPT_W-1:0] rpt0_i,
    input  logic [RPT_W-1:0] rpt1_i,
    input  logic             abort_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic             data_out_o,
    output logic             data_vld_o,
    output logic             busy_o,
    output logic             owner_o,
    output logic             done_o,
    output logic             aborted_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [RPT_W-1:0]   cnt_q, cnt_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               data_q, data_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               grant_ch;
    logic [LEN_W-1:0]   grant_len;
    logic [LEN_W-1:0]   start_idx;   // index loaded at grant
    logic [LEN_W-1:0]   end_idx;     // index of the final bit of one repetition
    logic [LEN_W-1:0]   wrap_idx;    // index reloaded after end_idx
    logic [LEN_W-1:0]   step_idx;

    // With both requesting, the channel not served last wins; last_q resets
    // to 1 so channel 0 wins the first tie.
    assign grant_ch  = req1_i & (~req0_i | ~last_q);
    assign grant_len = grant_ch ? len1_i : len0_i;

`ifdef PATTERN_SEQ_SCHED_LSB_FIRST_EN
    assign start_idx = '0;
    assign end_idx   = len_q;
    assign wrap_idx  = '0;
    assign step_idx  = idx_q + LEN_W'(1);
`else
    assign start_idx = grant_len;
    assign end_idx   = '0;
    assign wrap_idx  = len_q;
    assign step_idx  = idx_q - LEN_W'(1);
`endif

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        data_d    = 1'b0;
        vld_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req0_i || req1_i) begin
                    pat_d   = grant_ch ? pat1_i : pat0_i;
                    len_d   = grant_len;
                    cnt_d   = grant_ch ? rpt1_i : rpt0_i;
                    idx_d   = start_idx;
                    ack0_d  = ~grant_ch;
                    ack1_d  = grant_ch;
                    owner_d = grant_ch;
                    last_d  = grant_ch;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    data_d = pat_q[idx_q];
                    vld_d  = 1'b1;
                    if (idx_q == end_idx) begin
                        // cnt_q stays 0 for continuous jobs, so they never finish here
                        if (cnt_q == RPT_W'(1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            idx_d = wrap_idx;
                            if (cnt_q != '0) cnt_d = cnt_q - RPT_W'(1);
                        end
                    end else begin
                        idx_d = step_idx;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            data_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign ack0_o     = ack0_q;
    assign ack1_o     = ack1_q;
    assign data_out_o = data_q;
    assign data_vld_o = vld_q;
    assign busy_o     = busy_q;
    assign owner_o    = owner_q;
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;

endmodule

// File: doc/pattern_seq_sched.md
# pattern_seq_sched

Scheduler that shares one serial pattern generator between two requesters. Each requester hands over a pattern, a length and a repeat count through a req/ack handshake. The block arbitrates round-robin, then shifts the granted pattern out one bit per clock for the requested number of repetitions. It sits in front of the serial sequence-output path and replaces fixed hard-wired pattern generators.

## Interface
- PAT_W, 16, maximum pattern length in bits (≥2)
- LEN_W, $clog2(PAT_W), width of length fields
- RPT_W, 8, width of repeat-count fields

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0 / req1  in  1  request from channel 0 / 1, held high until ack
- pat0 / pat1  in  PAT_W  pattern, bit [len] sent first (MSB-first)
- len0 / len1  in  LEN_W  pattern length minus 1 (5 → 6 bits)
- rpt0 / rpt1  in  RPT_W  repetitions; 0 = continuous until abort
- abort  in  1  terminate the current job
- ack0 / ack1  out  1  one-cycle pulse: request accepted, inputs latched
- data_out  out  1  serial bit
- data_vld  out  1  data_out valid
- busy  out  1  job in progress
- owner  out  1  channel of current or last job
- done  out  1  one-cycle pulse coincident with the last valid bit of a job
- aborted  out  1  one-cycle pulse after an abort takes effect

## Operation
- Reset values: all outputs 0, FSM IDLE, last-served register = 1, so channel 0 wins the first tie.
- FSM states: IDLE and RUN.
- **IDLE**
  - If any req is high at an edge, grant a channel:
    - single requester wins;
    - both requesting: the channel not last served wins.
  - On that edge:
    - latch pat/len/rpt;
    - ackN <= 1;
    - owner <= N;
    - last-served <= N;
    - bit index <= len;
    - repeat counter <= rpt;
    - busy <= 1;
    - go to RUN.
  - The ungranted request stays pending (req still high), with no ack.
- **RUN**
  - Each edge: data_out <= latched pat[index], data_vld <= 1.
  - Index decrements, wrapping from 0 back to len.
  - On wrap with rpt ≠ 0, the repeat counter decrements.
  - When index = 0 and the counter = 1 (final bit of final repetition):
    - done <= 1 on the same edge that drives the bit;
    - state goes to IDLE;
    - busy <= 0.
  - With rpt = 0, the counter is ignored and the job runs until abort.
- **Abort**
  - abort sampled high in RUN: on that edge, data_vld <= 0, busy <= 0, aborted <= 1, state goes to IDLE, done stays 0.
  - abort in IDLE is ignored; no pulse.
  - abort in the same cycle as a grant is ignored.
- req changes while its channel is running have no effect; latched values are used.
- len = 0 yields a 1-bit pattern.
- Reset mid-job: immediate return to reset values; latched job discarded.

## Timing
- Grant edge E0: ack high for cycle E0..E1.
- First data bit valid after E1.
- Bit k of the job is valid after edge E(k+1).
- One job emits (len+1)·rpt bits contiguously, data_vld high throughout.
- done is high exactly during the final data_vld cycle.
- Earliest next grant is the edge after the done cycle, giving a minimum gap of one cycle with data_vld = 0 between jobs.
- Ack-to-first-bit latency is 1 cycle.
- After abort, data_vld drops on the edge that samples abort.

## Configuration
- PATTERN_SEQ_SCHED_LSB_FIRST_EN:
  - Defined: bit order reverses to pat[0] first, pat[len] last. The index counts 0 up to len and wraps to 0.
  - Undefined: MSB-first as described above.
  - Handshake, counts and timing are identical in both builds.

## Test plan
- req0, pat0 = 6'b001011, len0 = 5, rpt0 = 2:
  - ack0 pulse;
  - data_out 0,0,1,0,1,1,0,0,1,0,1,1 with data_vld high for 12 cycles;
  - done on the 12th;
  - busy then low.
- req0 and req1 both high from reset:
  - channel 0 is served first, then channel 1 after a one-cycle gap;
  - repeat with both high again: channel 0 is served first again, since last-served = 1.
- rpt0 = 0, pat0 = 2'b10, len0 = 1:
  - output alternates 1,0,… indefinitely;
  - abort after 7 bits: data_vld low next edge, aborted pulse, no done.
- len1 = 0, pat1[0] = 1, rpt1 = 3: three 1 bits, done on the third.
- Assert rst_n low mid-job:
  - all outputs 0 asynchronously;
  - a new req0 after release is granted normally.
- LSB_FIRST build, pattern 6'b001011: output 1,1,0,1,0,0.
